// File: rtl/serial_paralelo_align.sv
// serial_paralelo_align
// Receive-side lane deserializer. It consumes an MSB-first serial stream, one
// bit per clk_32f. It hunts for the COM symbol and locks after LOCK_COUNT
// consecutive COMs that sit on byte boundaries. Once locked, it delivers
// parallel bytes with a valid flag and a byte strobe.
//
// Optional feature macro: SERIAL_PARALELO_LOSS_OF_LOCK_EN
//   When defined, a COM seen off a byte boundary while LOCKED drops the lane
//   back to HUNT. When undefined, the lane leaves LOCKED only through reset.
module serial_paralelo_align #(
    parameter logic [7:0]  COM_SYMBOL  = 8'hBC,
    parameter logic [7:0]  IDLE_SYMBOL = 8'h7C,
    parameter int unsigned LOCK_COUNT  = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

    state_t     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [3:0] com_cnt_q,  com_cnt_d;
    logic [6:0] sr_q,       sr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q,    valid_d;
    logic       strobe_q,   strobe_d;
    logic       active_q,   active_d;

    logic [7:0] win;
    logic       is_com;
    logic       is_idle;
    logic       boundary;

    // The byte window includes the bit that is arriving now, so a symbol is
    // recognised on the same edge that its last bit is sampled.
    always_comb begin
        win      = {sr_q, data_in};
        is_com   = (win == COM_SYMBOL);
        is_idle  = (win == IDLE_SYMBOL);
        boundary = (bit_cnt_q == 3'd7);
    end

    // Next-state logic: alignment FSM, byte delivery and output flags.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q + 3'd1;
        com_cnt_d  = com_cnt_q;
        sr_d       = win[6:0];
        data_out_d = data_out_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        active_d   = active_q;

        case (state_q)
            ST_HUNT: begin
                if (is_com) begin
                    // The comma's last bit defines the byte phase. Counting
                    // restarts here, so the next boundary comes 8 edges later.
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    if (LOCK_CNT == 4'd1) begin
                        state_d  = ST_LOCKED;
                        active_d = 1'b1;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end

            ST_ALIGN: begin
                // Only boundary edges matter here. A comma between boundaries
                // is ignored.
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if ((com_cnt_q + 4'd1) == LOCK_CNT) begin
                            state_d  = ST_LOCKED;
                            active_d = 1'b1;
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        com_cnt_d = 4'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (boundary) begin
                    data_out_d = win;
                    strobe_d   = 1'b1;
                    valid_d    = !(is_com || is_idle);
                end
`ifdef SERIAL_PARALELO_LOSS_OF_LOCK_EN
                else if (is_com) begin
                    // A comma off the boundary means the byte phase has
                    // slipped. Drop lock but keep the last delivered byte.
                    state_d   = ST_HUNT;
                    com_cnt_d = 4'd0;
                    active_d  = 1'b0;
                    valid_d   = 1'b0;
                end
`endif
            end

            default: begin
                state_d = ST_HUNT;
            end
        endcase
    end

    // State and output registers, with asynchronous active-low clear.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_HUNT;
            bit_cnt_q  <= 3'd0;
            com_cnt_q  <= 4'd0;
            sr_q       <= 7'd0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            sr_q       <= sr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule

// File: doc/serial_paralelo_align.md
Name: serial_paralelo_align

Overview:
- Receive-side counterpart of the TX lane serializer. One instance per lane.
- Consumes the MSB-first serial bit stream one bit per clk_32f.
- Finds byte alignment by hunting for the COM symbol and declares the lane active after LOCK_COUNT consecutive aligned COMs.
- Then delivers parallel bytes with a valid flag to the downstream 8-to-32 mux stage.

Parameters:
- COM_SYMBOL, 8'hBC, alignment/comma symbol.
- IDLE_SYMBOL, 8'h7C, filler symbol (not valid data).
- LOCK_COUNT, 4, consecutive aligned COMs required to reach LOCKED (legal range 1..15).

Ports:
- clk_32f  input  1  bit clock; the single clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  1  serial bit, MSB of each byte first.
- data_out  output  8  last received byte while LOCKED.
- valid_out  output  1  data_out holds a data byte (not COM/IDLE).
- byte_strobe  output  1  one-cycle pulse at each byte boundary while LOCKED.
- active  output  1  lane aligned and locked.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately, mid-operation included):
  - data_out=8'h00; valid_out, byte_strobe, active = 0.
  - Internal state: state=HUNT, bit_cnt=0, com_cnt=0, shift register=0.
- Window: win = {sr[6:0], data_in}, formed combinationally. sr shifts in data_in on every edge in every state.
- bit_cnt is 3 bits, counting 0..7 with wrap. A byte boundary is an edge where bit_cnt==7.
- HUNT:
  - Evaluated every edge.
  - If win==COM_SYMBOL: bit_cnt<=0 and com_cnt<=1. Go to ALIGN, or straight to LOCKED if LOCK_COUNT==1.
  - Otherwise stay in HUNT; bit_cnt is don't-care.
- ALIGN:
  - bit_cnt increments each edge.
  - At a boundary, if win==COM_SYMBOL: com_cnt++. On reaching LOCK_COUNT, go to LOCKED and set active<=1 on that same edge.
  - At a boundary, if win!=COM_SYMBOL: go to HUNT, com_cnt<=0.
- LOCKED:
  - At each boundary: data_out<=win and byte_strobe<=1.
  - valid_out<=1 unless win is COM_SYMBOL or IDLE_SYMBOL, in which case valid_out<=0.
  - Between boundaries: byte_strobe=0; data_out and valid_out hold.
  - active stays 1 until reset (see optional feature).
- Latency: the last bit of a byte is on data_in during cycle n. data_out, valid_out and byte_strobe update at the edge ending cycle n, with no additional pipeline.
- Simultaneous events: reset dominates everything. In ALIGN, the boundary check takes priority; a COM seen in win at a non-boundary edge is ignored.
- Streams with no COM leave the block in HUNT indefinitely, with all outputs 0.

Optional Feature:
- Macro: SERIAL_PARALELO_LOSS_OF_LOCK_EN.
- Defined: in LOCKED, if win==COM_SYMBOL at an edge where bit_cnt!=7 (misaligned comma):
  - go to HUNT and clear com_cnt;
  - active<=0, valid_out<=0 and byte_strobe<=0 on that edge;
  - data_out holds its value.
- Not defined: in LOCKED, misaligned COMs are ignored; lock is left only through reset.

Test Plan:
1. Reset low, then high. Send BC,BC,BC,BC,A5 MSB-first with no offset.
   - Expected: active rises at the edge ending the 4th BC byte.
   - At the A5 boundary: data_out=8'hA5, valid_out=1, byte_strobe pulses 1 cycle.
2. Send 3 junk bits 3'b101, then BC×4, then 3C.
   - Expected: alignment found despite the offset; active=1; data_out=8'h3C, valid_out=1.
3. Send BC,BC,BC,12,BC,BC,BC,BC,55.
   - Expected: the 12 forces a return to HUNT and active stays 0.
   - The second BC run locks; 55 is then delivered with valid_out=1.
4. LOCKED, send 7C then 9E.
   - Expected: at the 7C boundary, byte_strobe=1, data_out=8'h7C, valid_out=0.
   - At the next boundary, data_out=8'h9E, valid_out=1.
5. LOCKED, streaming data; drive reset=0 mid-byte.
   - Expected: all outputs are 0 immediately, without waiting for a clock edge.
   - After release, the block re-hunts and needs LOCK_COUNT COMs again.
6. Macro defined, LOCKED: inject a BC pattern straddling a boundary (shifted by 2 bits).
   - Expected: active=0 on the detecting edge, then a relock on BC×4.
   - Macro undefined: active stays 1.
